// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet RX header parser.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;
    localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DST     = 3'd1,
        ST_SRC     = 3'd2,
        ST_TYPE    = 3'd3,
        ST_VTAG    = 3'd4,
        ST_PAYLOAD = 3'd5,
        ST_DROP    = 3'd6
    } hdr_state_t;

endpackage

// File: rtl/eth_type_match.sv
// Combinational EtherType table lookup; entry 0 is the most significant
// 16-bit slice of TYPE_LIST, so the list reads left-to-right as entry 0..N-1.
module eth_type_match #(
    parameter int                      NUM_TYPES = 2,
    parameter logic [NUM_TYPES*16-1:0] TYPE_LIST = {16'h0800, 16'h0806}
) (
    input  logic [15:0]          i_eth_type,
    output logic [NUM_TYPES-1:0] o_type_hit
);

    always_comb begin
        o_type_hit = '0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            o_type_hit[i] = (i_eth_type == TYPE_LIST[(NUM_TYPES-1-i)*16 +: 16]);
        end
    end

endmodule

// File: rtl/eth_hdr_parser.sv
// Ethernet RX header parser: captures DST/SRC/EtherType (plus one optional
// 802.1Q tag), filters by MAC and EtherType, and forwards accepted payload.
module eth_hdr_parser
    import eth_pkg::*;
#(
    parameter int                      NUM_TYPES = 2,
    parameter logic [NUM_TYPES*16-1:0] TYPE_LIST = {16'h0800, 16'h0806},
    parameter int                      VLAN_EN   = 1,
    parameter int                      MCAST_EN  = 0
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    input  logic                 sof,
    input  logic [47:0]          local_mac,
    input  logic                 promisc_en,
    output logic                 hdr_valid,
    output logic [47:0]          hdr_dst_mac,
    output logic [47:0]          hdr_src_mac,
    output logic [15:0]          hdr_eth_type,
    output logic                 hdr_vlan_present,
    output logic [15:0]          hdr_vlan_tci,
    output logic [NUM_TYPES-1:0] type_hit,
    output logic                 hdr_accept,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    output logic                 m_last,
    output logic                 m_abort,
    output logic                 err_runt
);

    hdr_state_t r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;

    logic [47:0] r_dst, r_src;
    logic [7:0]  r_type_hi;
    logic [15:0] r_tci;
    logic        r_vlan_seen;

    logic [47:0] r_hdr_dst, r_hdr_src;
    logic [15:0] r_hdr_type, r_hdr_tci;
    logic        r_hdr_vlan, r_hdr_accept, r_hdr_valid;
    logic [NUM_TYPES-1:0] r_type_hit;
    logic [7:0]  r_m_data;
    logic        r_m_valid, r_m_last, r_m_abort, r_err_runt;

    logic [15:0]          w_type_word;
    logic [NUM_TYPES-1:0] w_hit;
    logic                 w_mac_ok, w_accept, w_vtag_enter;
    logic                 w_hdr_done, w_runt, w_abort, w_fwd;

    assign w_type_word  = {r_type_hi, s_data};
    assign w_vtag_enter = (VLAN_EN != 0) && (w_type_word == ETH_TYPE_VLAN) && !r_vlan_seen;
    assign w_mac_ok     = (r_dst == local_mac) || (r_dst == MAC_BCAST) ||
                          ((MCAST_EN != 0) && r_dst[40]) || promisc_en;
    assign w_accept     = w_mac_ok && (|w_hit);
    assign w_fwd        = (r_state == ST_PAYLOAD) && !sof && s_valid;

    eth_type_match #(
        .NUM_TYPES (NUM_TYPES),
        .TYPE_LIST (TYPE_LIST)
    ) u_type_match (
        .i_eth_type (w_type_word),
        .o_type_hit (w_hit)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // sof has priority in every state: it always restarts the header walk.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hdr_done  = 1'b0;
        w_runt      = 1'b0;
        w_abort     = 1'b0;
        if (sof) begin
            w_abort = (r_state == ST_PAYLOAD);
            if (s_valid && s_last) begin
                w_runt      = 1'b1;
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end else begin
                w_state_nxt = ST_DST;
                w_cnt_nxt   = s_valid ? 3'd1 : 3'd0;
            end
        end else if (s_valid && s_last &&
                     (r_state inside {ST_DST, ST_SRC, ST_TYPE, ST_VTAG})) begin
            w_runt      = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
        end else if (s_valid) begin
            case (r_state)
                ST_DST: begin
                    if (r_cnt == 3'd5) begin
                        w_state_nxt = ST_SRC;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                ST_SRC: begin
                    if (r_cnt == 3'd5) begin
                        w_state_nxt = ST_TYPE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
                ST_TYPE: begin
                    if (r_cnt == 3'd0) begin
                        w_cnt_nxt = 3'd1;
                    end else if (w_vtag_enter) begin
                        w_state_nxt = ST_VTAG;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_hdr_done  = 1'b1;
                        w_state_nxt = w_accept ? ST_PAYLOAD : ST_DROP;
                        w_cnt_nxt   = 3'd0;
                    end
                end
                ST_VTAG: begin
                    if (r_cnt == 3'd0) begin
                        w_cnt_nxt = 3'd1;
                    end else begin
                        w_state_nxt = ST_TYPE;
                        w_cnt_nxt   = 3'd0;
                    end
                end
                ST_PAYLOAD, ST_DROP: begin
                    if (s_last) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Working registers shift in the live frame; the r_hdr_* copies only
    // move at the decision so the published fields hold until the next one.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_dst        <= '0;
            r_src        <= '0;
            r_type_hi    <= '0;
            r_tci        <= '0;
            r_vlan_seen  <= 1'b0;
            r_hdr_dst    <= '0;
            r_hdr_src    <= '0;
            r_hdr_type   <= '0;
            r_hdr_tci    <= '0;
            r_hdr_vlan   <= 1'b0;
            r_hdr_accept <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_type_hit   <= '0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_abort    <= 1'b0;
            r_err_runt   <= 1'b0;
        end else begin
            r_hdr_valid <= w_hdr_done;
            r_err_runt  <= w_runt;
            r_m_abort   <= w_abort;
            r_m_valid   <= w_fwd;
            r_m_last    <= w_fwd && s_last;
            if (w_fwd) begin
                r_m_data <= s_data;
            end

            if (sof) begin
                r_vlan_seen <= 1'b0;
                r_tci       <= '0;
                if (s_valid) begin
                    r_dst <= {r_dst[39:0], s_data};
                end
            end else if (s_valid) begin
                case (r_state)
                    ST_DST:  r_dst <= {r_dst[39:0], s_data};
                    ST_SRC:  r_src <= {r_src[39:0], s_data};
                    ST_TYPE: begin
                        if (r_cnt == 3'd0) begin
                            r_type_hi <= s_data;
                        end else if (w_vtag_enter) begin
                            r_vlan_seen <= 1'b1;
                        end
                    end
                    ST_VTAG: r_tci <= {r_tci[7:0], s_data};
                    default: ;
                endcase
            end

            if (w_hdr_done) begin
                r_hdr_dst    <= r_dst;
                r_hdr_src    <= r_src;
                r_hdr_type   <= w_type_word;
                r_hdr_tci    <= r_tci;
                r_hdr_vlan   <= r_vlan_seen;
                r_type_hit   <= w_hit;
                r_hdr_accept <= w_accept;
            end
        end
    end

    assign hdr_valid        = r_hdr_valid;
    assign hdr_dst_mac      = r_hdr_dst;
    assign hdr_src_mac      = r_hdr_src;
    assign hdr_eth_type     = r_hdr_type;
    assign hdr_vlan_present = r_hdr_vlan;
    assign hdr_vlan_tci     = r_hdr_tci;
    assign type_hit         = r_type_hit;
    assign hdr_accept       = r_hdr_accept;
    assign m_data           = r_m_data;
    assign m_valid          = r_m_valid;
    assign m_last           = r_m_last;
    assign m_abort          = r_m_abort;
    assign err_runt         = r_err_runt;

endmodule

// File: tb/tb_eth_hdr_parser.sv
// Directed bench for eth_hdr_parser: frames built byte-by-byte, outputs
// observed by a negedge monitor and compared against hand-derived values.
module tb_eth_hdr_parser;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_data;
    logic        s_valid, s_last, sof;
    logic [47:0] local_mac;
    logic        promisc_en;
    logic        hdr_valid;
    logic [47:0] hdr_dst_mac, hdr_src_mac;
    logic [15:0] hdr_eth_type, hdr_vlan_tci;
    logic        hdr_vlan_present;
    logic [1:0]  type_hit;
    logic        hdr_accept;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_abort, err_runt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hvCount, hvCyc, mCount, mLastCount, mLastIdx, abortCount, runtCount;
    logic [31:0] mFold, expFold;
    int startCyc, lastLat;

    localparam logic [47:0] LOCAL  = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SRC_A  = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [47:0] SRC_B  = 48'h5A_5B_5C_5D_5E_5F;
    localparam logic [47:0] FOREIGN = 48'h02_99_88_77_66_55;
    localparam logic [47:0] MCAST  = 48'h01_00_5E_00_00_01;

    eth_hdr_parser dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_last           (s_last),
        .sof              (sof),
        .local_mac        (local_mac),
        .promisc_en       (promisc_en),
        .hdr_valid        (hdr_valid),
        .hdr_dst_mac      (hdr_dst_mac),
        .hdr_src_mac      (hdr_src_mac),
        .hdr_eth_type     (hdr_eth_type),
        .hdr_vlan_present (hdr_vlan_present),
        .hdr_vlan_tci     (hdr_vlan_tci),
        .type_hit         (type_hit),
        .hdr_accept       (hdr_accept),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_last           (m_last),
        .m_abort          (m_abort),
        .err_runt         (err_runt)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc++;

    // Monitor samples on the falling edge, half a cycle from any DUT update.
    always @(negedge aclk) begin
        if (hdr_valid) begin
            hvCount++;
            hvCyc = cyc;
        end
        if (m_valid) begin
            mCount++;
            mFold = mFold * 3 + {24'd0, m_data};
            if (m_last) begin
                mLastCount++;
                mLastIdx = mCount;
            end
        end
        if (m_abort) abortCount++;
        if (err_runt) runtCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clearMon();
        hvCount = 0; hvCyc = 0; mCount = 0; mLastCount = 0; mLastIdx = 0;
        abortCount = 0; runtCount = 0; mFold = 0; expFold = 0;
    endtask

    task automatic sendByte(input logic [7:0] d, input logic v, input logic l, input logic f);
        s_data = d; s_valid = v; s_last = l; sof = f;
        @(posedge aclk);
        #1;
        s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) sendByte(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // stopAt < 0 sends the whole frame; otherwise byte stopAt is the final
    // one driven, flagged s_last only when lastAtStop is set.
    task automatic applyStimulus(input logic [47:0] dst, input logic [47:0] src,
                                 input logic [15:0] typ, input bit vlan,
                                 input logic [15:0] tci, input int n,
                                 input bit stall, input int stopAt,
                                 input bit lastAtStop);
        logic [7:0] q[$];
        int hdrLen;
        logic l;
        q = {};
        for (int k = 0; k < 6; k++) q.push_back(dst[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) q.push_back(src[47-8*k -: 8]);
        if (vlan) begin
            q.push_back(8'h81); q.push_back(8'h00);
            q.push_back(tci[15:8]); q.push_back(tci[7:0]);
        end
        q.push_back(typ[15:8]); q.push_back(typ[7:0]);
        hdrLen = q.size();
        for (int k = 0; k < n; k++) q.push_back(8'hA0 + 8'(k * 7));
        startCyc = cyc;
        for (int i = 0; i < q.size(); i++) begin
            if (stopAt >= 0 && i > stopAt) break;
            l = (stopAt < 0) ? (i == q.size() - 1) : ((i == stopAt) && lastAtStop);
            if (i >= hdrLen) expFold = expFold * 3 + {24'd0, q[i]};
            sendByte(q[i], 1'b1, l, i == 0);
            if (stall && i < hdrLen - 1) idle(1);
        end
    endtask

    task automatic checkHdr(input string t, input logic [47:0] dst, input logic [47:0] src,
                            input logic [15:0] typ, input logic vlan, input logic [15:0] tci,
                            input logic [1:0] hit, input logic acc);
        checkOutput({t, ".dst"},  64'(hdr_dst_mac), 64'(dst));
        checkOutput({t, ".src"},  64'(hdr_src_mac), 64'(src));
        checkOutput({t, ".type"}, 64'(hdr_eth_type), 64'(typ));
        checkOutput({t, ".vlan"}, 64'(hdr_vlan_present), 64'(vlan));
        checkOutput({t, ".tci"},  64'(hdr_vlan_tci), 64'(tci));
        checkOutput({t, ".hit"},  64'(type_hit), 64'(hit));
        checkOutput({t, ".acc"},  64'(hdr_accept), 64'(acc));
    endtask

    initial begin
        s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; sof = 1'b0;
        local_mac = LOCAL; promisc_en = 1'b0;
        aresetn = 1'b0;
        clearMon();
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("reset.outs", 64'({hdr_valid, hdr_accept, type_hit, m_valid, m_last,
                    m_abort, err_runt, hdr_vlan_present}), 64'd0);
        checkOutput("reset.dst", 64'(hdr_dst_mac), 64'd0);
        aresetn = 1'b1;
        idle(2);

        // ARP broadcast with 10 payload bytes
        clearMon();
        applyStimulus(BCAST, SRC_A, 16'h0806, 0, 16'h0, 10, 0, -1, 0);
        lastLat = hvCyc - startCyc;
        idle(4);
        checkHdr("arp", BCAST, SRC_A, 16'h0806, 0, 16'h0, 2'b10, 1);
        checkOutput("arp.hv",    64'(hvCount), 64'd1);
        checkOutput("arp.lat",   64'(lastLat), 64'd14);
        checkOutput("arp.mcnt",  64'(mCount), 64'd10);
        checkOutput("arp.mlast", 64'(mLastCount), 64'd1);
        checkOutput("arp.lidx",  64'(mLastIdx), 64'd10);
        checkOutput("arp.data",  64'(mFold), 64'(expFold));

        // IPv4 unicast with VLAN tag
        clearMon();
        applyStimulus(LOCAL, SRC_B, 16'h0800, 1, 16'h6005, 6, 0, -1, 0);
        lastLat = hvCyc - startCyc;
        idle(4);
        checkHdr("vlan", LOCAL, SRC_B, 16'h0800, 1, 16'h6005, 2'b01, 1);
        checkOutput("vlan.lat",  64'(lastLat), 64'd18);
        checkOutput("vlan.mcnt", 64'(mCount), 64'd6);
        checkOutput("vlan.data", 64'(mFold), 64'(expFold));

        // Foreign unicast, then same with promiscuous mode
        clearMon();
        applyStimulus(FOREIGN, SRC_A, 16'h0800, 0, 16'h0, 5, 0, -1, 0);
        idle(4);
        checkOutput("foreign.hv",   64'(hvCount), 64'd1);
        checkOutput("foreign.acc",  64'(hdr_accept), 64'd0);
        checkOutput("foreign.mcnt", 64'(mCount), 64'd0);
        clearMon();
        promisc_en = 1'b1;
        applyStimulus(FOREIGN, SRC_A, 16'h0800, 0, 16'h0, 5, 0, -1, 0);
        idle(4);
        promisc_en = 1'b0;
        checkOutput("promisc.acc",  64'(hdr_accept), 64'd1);
        checkOutput("promisc.mcnt", 64'(mCount), 64'd5);

        // Stalled header: 13 idle cycles inserted between header bytes
        clearMon();
        applyStimulus(BCAST, SRC_A, 16'h0806, 0, 16'h0, 10, 1, -1, 0);
        lastLat = hvCyc - startCyc;
        idle(4);
        checkHdr("stall", BCAST, SRC_A, 16'h0806, 0, 16'h0, 2'b10, 1);
        checkOutput("stall.lat",  64'(lastLat), 64'd27);
        checkOutput("stall.mcnt", 64'(mCount), 64'd10);

        // Runt: s_last on byte 9
        clearMon();
        applyStimulus(BCAST, SRC_B, 16'h0806, 0, 16'h0, 4, 0, 9, 1);
        idle(4);
        checkOutput("runt.err",  64'(runtCount), 64'd1);
        checkOutput("runt.hv",   64'(hvCount), 64'd0);
        checkOutput("runt.mcnt", 64'(mCount), 64'd0);

        // sof and s_last together in IDLE
        clearMon();
        sendByte(8'hFF, 1'b1, 1'b1, 1'b1);
        idle(3);
        checkOutput("sofLast.err", 64'(runtCount), 64'd1);
        checkOutput("sofLast.hv",  64'(hvCount), 64'd0);

        // New sof mid-payload: 5 bytes of A, then full frame B
        clearMon();
        applyStimulus(BCAST, SRC_A, 16'h0806, 0, 16'h0, 10, 0, 18, 0);
        applyStimulus(BCAST, SRC_B, 16'h0806, 0, 16'h0, 4, 0, -1, 0);
        idle(4);
        checkOutput("abort.cnt",   64'(abortCount), 64'd1);
        checkOutput("abort.hv",    64'(hvCount), 64'd2);
        checkOutput("abort.mcnt",  64'(mCount), 64'd9);
        checkOutput("abort.mlast", 64'(mLastCount), 64'd1);
        checkOutput("abort.lidx",  64'(mLastIdx), 64'd9);
        checkOutput("abort.data",  64'(mFold), 64'(expFold));
        checkOutput("abort.src",   64'(hdr_src_mac), 64'(SRC_B));

        // Asynchronous reset in the middle of SRC
        clearMon();
        applyStimulus(LOCAL, SRC_A, 16'h0800, 0, 16'h0, 4, 0, 9, 0);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("arst.outs", 64'({hdr_valid, hdr_accept, type_hit, m_valid, m_last,
                    m_abort, err_runt, hdr_vlan_present}), 64'd0);
        checkOutput("arst.dst",  64'(hdr_dst_mac), 64'd0);
        checkOutput("arst.src",  64'(hdr_src_mac), 64'd0);
        checkOutput("arst.type", 64'(hdr_eth_type), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        idle(2);
        checkOutput("arst.abort", 64'(abortCount), 64'd0);
        clearMon();
        applyStimulus(LOCAL, SRC_A, 16'h0800, 0, 16'h0, 3, 0, -1, 0);
        idle(4);
        checkHdr("postRst", LOCAL, SRC_A, 16'h0800, 0, 16'h0, 2'b01, 1);
        checkOutput("postRst.mcnt", 64'(mCount), 64'd3);

        // EtherType outside the table
        clearMon();
        applyStimulus(BCAST, SRC_B, 16'h86DD, 0, 16'h0, 3, 0, -1, 0);
        idle(4);
        checkHdr("noType", BCAST, SRC_B, 16'h86DD, 0, 16'h0, 2'b00, 0);
        checkOutput("noType.mcnt", 64'(mCount), 64'd0);

        // Second 0x8100 is an ordinary EtherType
        clearMon();
        applyStimulus(LOCAL, SRC_A, 16'h8100, 1, 16'h0123, 3, 0, -1, 0);
        idle(4);
        checkHdr("dblVlan", LOCAL, SRC_A, 16'h8100, 1, 16'h0123, 2'b00, 0);

        // Multicast destination rejected with MCAST_EN=0
        clearMon();
        applyStimulus(MCAST, SRC_A, 16'h0800, 0, 16'h0, 3, 0, -1, 0);
        idle(4);
        checkOutput("mcast.hit",  64'(type_hit), 64'b01);
        checkOutput("mcast.acc",  64'(hdr_accept), 64'd0);
        checkOutput("mcast.mcnt", 64'(mCount), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_hdr_parser.md
Name: eth_hdr_parser

Overview:
Parametrised successor to the Ethernet RX header checker. Consumes the byte stream after preamble/SFD detection and captures destination MAC, source MAC and EtherType, including one optional 802.1Q VLAN tag. Applies a configurable MAC filter and EtherType match table, then forwards accepted payload bytes downstream. Sits between the preamble/SFD detector and the ARP/IPv4 RX blocks.

Parameters:
NUM_TYPES, 2, number of EtherType match entries (1..8)
TYPE_LIST, {16'h0800,16'h0806}, packed NUM_TYPES x 16 EtherType table; entry i drives type_hit[i]
VLAN_EN, 1, 1 = parse one 0x8100 tag; 0 = treat 0x8100 as a plain EtherType
MCAST_EN, 0, 1 = accept any multicast destination (dst[40]=1)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
s_data  in  8  RX byte
s_valid  in  1  s_data valid; low = stall, no byte consumed
s_last  in  1  last byte of frame, qualified by s_valid
sof  in  1  preamble/SFD detected; the same cycle's s_data (if s_valid) is dst byte 0
local_mac  in  48  station MAC, sampled at the hdr_valid decision
promisc_en  in  1  bypass MAC filter
hdr_valid  out  1  one-cycle pulse: header complete, fields stable until next hdr_valid
hdr_dst_mac  out  48  captured destination
hdr_src_mac  out  48  captured source
hdr_eth_type  out  16  inner EtherType
hdr_vlan_present  out  1  tag seen
hdr_vlan_tci  out  16  TCI, 0 if no tag
type_hit  out  NUM_TYPES  one-hot/zero EtherType match
hdr_accept  out  1  filter pass AND |type_hit, valid with hdr_valid
m_data  out  8  payload byte
m_valid  out  1  payload valid
m_last  out  1  last payload byte
m_abort  out  1  one-cycle pulse: current payload truncated
err_runt  out  1  one-cycle pulse: s_last before header complete

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0.
- States: IDLE, DST, SRC, TYPE, VTAG, PAYLOAD, DROP. Every counted step consumes only bytes with s_valid=1.
- IDLE: sof & s_valid -> store byte 0 MSB-first, go DST with count=1. sof without s_valid -> DST with count=0.
- DST: 6 bytes total -> SRC. SRC: 6 bytes -> TYPE. TYPE: 2 bytes, first byte high.
- At the 2nd TYPE byte: if VLAN_EN and type==0x8100 and no tag is yet seen -> VTAG (2 TCI bytes), then TYPE again. A second 0x8100 is an ordinary EtherType.
- At the final TYPE byte: register fields; next cycle hdr_valid=1 (latency 1 cycle after the last header byte). Then go PAYLOAD if hdr_accept, else DROP.
- MAC filter passes on any of: dst==local_mac, dst==FF:FF:FF:FF:FF:FF, (MCAST_EN & dst[40]), promisc_en.
- type_hit[i] = (eth_type == TYPE_LIST[i]). If entries are duplicated, all matching bits set.
- PAYLOAD: m_data/m_valid/m_last = registered s_data/s_valid/s_last, 1-cycle latency. s_last -> IDLE.
- DROP: discard bytes until s_last -> IDLE. m_valid stays 0.
- s_last in DST/SRC/TYPE/VTAG: err_runt pulse next cycle, no hdr_valid, -> IDLE.
- sof while not IDLE: restart at DST with the sof byte. If the block was in PAYLOAD, m_abort pulses next cycle and m_last is not asserted.
- If sof and s_last fall in the same cycle in IDLE: err_runt, stay IDLE.
- Async reset mid-frame: immediate IDLE, outputs cleared, no m_abort.
- Byte counter: 3 bits, clears at each state change, no wrap beyond 5.

Decomposition:
- eth_pkg: ETH_TYPE_IPV4, ETH_TYPE_ARP, ETH_TYPE_VLAN, MAC_BCAST constants; hdr state enum.
- Sub-module eth_type_match: combinational NUM_TYPES comparator producing type_hit.
- The top module holds the FSM, capture registers and payload pipe.

Test Plan:
- ARP broadcast: dst FF..FF, type 0806, 10 payload bytes -> hdr_valid once, type_hit=2'b10, hdr_accept=1, 10 m_valid bytes, m_last on the 10th.
- IPv4 unicast to local_mac with VLAN tag 8100/TCI 0x6005 -> vlan_present=1, tci=0x6005, eth_type=0800, type_hit=2'b01, payload forwarded.
- Unicast to a foreign MAC, promisc_en=0 -> hdr_accept=0, no m_valid; repeat with promisc_en=1 -> payload forwarded.
- s_valid de-asserted every other cycle through the header -> fields identical to the gap-free case, hdr_valid delayed by the number of stall cycles.
- s_last at byte 9 -> err_runt pulse, no hdr_valid. New sof mid-payload -> m_abort pulse, then the next frame parses correctly.
- Assert aresetn low mid-SRC -> all outputs 0 immediately, and the next frame parses normally.
